// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack and the program counter:
// default address width, default stack depth and the CALL/RET op encoding.
package call_stack_pkg;

    // Address width shared with the program counter.
    localparam int ADDR_WIDTH  = 8;
    // Default number of return-address entries.
    localparam int STACK_DEPTH = 4;

    // Encoding follows the decoder strobes as {call, ret}.
    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_RET      = 2'b01,
        OP_CALL     = 2'b10,
        OP_TAILCALL = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic call, input logic ret);
        return op_e'({call, ret});
    endfunction

endpackage

// File: rtl/call_stack_if.sv
// Decoder/counter-side bundle for the return-address stack.
// Optional macro CALL_STACK_LEVEL_EN adds the `level` occupancy signal.
interface call_stack_if
    import call_stack_pkg::*;
#(
    parameter int BitCount = ADDR_WIDTH,
    parameter int Depth    = STACK_DEPTH
);
    logic                     call;
    logic                     ret;
    logic [BitCount-1:0]      pc;
    logic [BitCount-1:0]      target;
    logic                     clr_err;
    logic                     sel;
    logic [BitCount-1:0]      next_addr;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;
`ifdef CALL_STACK_LEVEL_EN
    logic [$clog2(Depth):0]   level;
`endif

    // Decoder / counter side.
    modport master (
        output call, ret, pc, target, clr_err,
        input  sel, next_addr, empty, full, overflow, underflow
`ifdef CALL_STACK_LEVEL_EN
        , input level
`endif
    );

    // Stack side.
    modport slave (
        input  call, ret, pc, target, clr_err,
        output sel, next_addr, empty, full, overflow, underflow
`ifdef CALL_STACK_LEVEL_EN
        , output level
`endif
    );

endinterface

// File: rtl/call_stack_mem.sv
// Depth x BitCount return-address storage: one write port, one
// asynchronous read port.
module call_stack_mem
    import call_stack_pkg::*;
#(
    parameter int BitCount = ADDR_WIDTH,
    parameter int Depth    = STACK_DEPTH,
    localparam int PtrW    = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PtrW-1:0]     waddr,
    input  logic [BitCount-1:0] wdata,
    input  logic [PtrW-1:0]     raddr,
    output logic [BitCount-1:0] rdata
);

    logic [BitCount-1:0] mem [Depth];

    // Write the addressed entry on a push or tail-call overwrite.
    // NOTE: the array has no reset; entries are only read while the stack
    // holds them, so clearing would cost logic for no observable effect.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack driving the program counter's load path (sel,
// next_addr) for CALL / RET / TAILCALL. Loads are combinational so the
// counter and the stack update on the same edge.
// Optional macro CALL_STACK_LEVEL_EN exposes the entry count as `level`.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int BitCount = ADDR_WIDTH,
    parameter int Depth    = STACK_DEPTH,
    localparam int PtrW    = $clog2(Depth),
    localparam int CntW    = $clog2(Depth) + 1
) (
    input  logic        clk,
    input  logic        reset,
    call_stack_if.slave bus
);

    logic [PtrW-1:0]     top;
    logic [CntW-1:0]     count;
    logic                overflow;
    logic                underflow;

    logic                is_empty;
    logic                is_full;
    op_e                 op;
    logic [BitCount-1:0] ret_addr;
    logic [BitCount-1:0] top_data;

    logic                sel;
    logic [BitCount-1:0] next_addr;
    logic                push;
    logic                pop;
    logic                we;
    logic [PtrW-1:0]     waddr;
    logic                set_ovf;
    logic                set_unf;

    assign is_empty = (count == '0);
    assign is_full  = (count == CntW'(Depth));
    assign op       = decode_op(bus.call, bus.ret);
    // Wraps modulo 2^BitCount, so pc=all-ones returns to 0.
    assign ret_addr = bus.pc + BitCount'(1);

    // Decode the strobes into the counter load and the stack update.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel       = 1'b0;
        next_addr = '0;
        push      = 1'b0;
        pop       = 1'b0;
        we        = 1'b0;
        waddr     = top;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        unique case (op)
            OP_NOP: ;
            OP_CALL: push = 1'b1;
            OP_RET: begin
                if (is_empty) begin
                    set_unf = 1'b1;
                end else begin
                    pop       = 1'b1;
                    sel       = 1'b1;
                    next_addr = top_data;
                end
            end
            OP_TAILCALL: begin
                if (is_empty) begin
                    push = 1'b1;
                end else begin
                    // Replace the current frame's return address in place.
                    sel       = 1'b1;
                    next_addr = bus.target;
                    we        = 1'b1;
                    waddr     = top;
                end
            end
            default: ;
        endcase
        if (push) begin
            sel       = 1'b1;
            next_addr = bus.target;
            we        = 1'b1;
            waddr     = top + PtrW'(1);
            // A push while full overwrites the oldest entry circularly.
            set_ovf   = is_full;
        end
    end

    // Pointer, occupancy and sticky error flags.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                top <= top + PtrW'(1);
                if (!is_full) begin
                    count <= count + CntW'(1);
                end
            end else if (pop) begin
                top   <= top - PtrW'(1);
                count <= count - CntW'(1);
            end
            // A setting event in the same cycle as clr_err wins.
            overflow  <= (overflow  & ~bus.clr_err) | set_ovf;
            underflow <= (underflow & ~bus.clr_err) | set_unf;
        end
    end

    call_stack_mem #(
        .BitCount (BitCount),
        .Depth    (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (ret_addr),
        .raddr (top),
        .rdata (top_data)
    );

    assign bus.sel       = sel;
    assign bus.next_addr = next_addr;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`ifdef CALL_STACK_LEVEL_EN
    assign bus.level     = count;
`endif

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Return-address stack that drives the program counter's load path (`SEL`, `in`) for CALL/RET control flow.
- On CALL it pushes the return address and steers the counter to the call target.
- On RET it pops and steers the counter back to the popped address.
- Sits between the instruction decoder and the program counter, in the same clock domain.

Parameters:
- BitCount, 8, address width; must match the program counter's BitCount.
- Depth, 4, number of stack entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- call  in  1  decoder CALL strobe, one cycle per instruction.
- ret  in  1  decoder RET strobe, one cycle per instruction.
- pc  in  BitCount  current program counter value (the counter's `out`).
- target  in  BitCount  CALL destination address.
- clr_err  in  1  clears the sticky error flags.
- sel  out  1  load request to the counter's SEL.
- next_addr  out  BitCount  load value to the counter's `in`.
- empty  out  1  stack holds 0 entries.
- full  out  1  stack holds Depth entries.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a RET occurred while empty.

Behaviour:
- Reset (reset low, asynchronous, at any time including mid-sequence):
  - count=0, top pointer=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, sel=0, next_addr=0.
  - Storage contents are not cleared and are unobservable while empty.
- sel and next_addr are combinational from call/ret/top-of-stack, so the counter loads at the same edge the stack updates. Zero-cycle latency; no wait states.
- Return address = pc+1, modulo 2^BitCount (pc=all-ones pushes 0).
- Operation decode {call,ret}:
  - 00 NOP: sel=0, next_addr=0, no state change.
  - 10 CALL: sel=1, next_addr=target. At the edge, pc+1 is written to top+1, top increments mod Depth, count increments.
  - 01 RET, not empty: sel=1, next_addr=mem[top]. At the edge, top decrements mod Depth, count decrements.
  - 01 RET, empty: sel=0, next_addr=0 (counter simply advances). underflow set at the edge; pointer and count unchanged.
  - 11 TAILCALL, not empty: sel=1, next_addr=target. mem[top] is overwritten with pc+1; count unchanged.
  - 11 TAILCALL, empty: identical to CALL.
- CALL while full:
  - Circular overwrite: write and pointer advance proceed, clobbering the oldest entry.
  - count stays at Depth; overflow set at the edge.
  - A later RET sequence returns the Depth most recent addresses correctly.
- Sticky flags:
  - overflow and underflow hold until clr_err=1 at an edge, or until reset.
  - If clr_err and a setting event occur in the same cycle, set wins.
- count width is $clog2(Depth)+1; full is count==Depth, empty is count==0.

Optional Feature:
- Macro: CALL_STACK_LEVEL_EN.
- Defined: adds output port `level`, width $clog2(Depth)+1, carrying the current count. Reset value 0. Updated at the same edge as the stack.
- Undefined: port and any associated logic are absent; all other behaviour is identical.

Decomposition:
- Shared package call_stack_pkg holds:
  - the default address width constant (shared with the program counter);
  - the default depth constant;
  - the op enum {OP_NOP, OP_CALL, OP_RET, OP_TAILCALL}, built from {call,ret}.
- One natural sub-module: call_stack_mem.
  - Depth x BitCount register array.
  - Single write port, single asynchronous read port at top.
  - No reset on the array.
- Pointer, count, flag and decode logic stay in call_stack.

Test Plan (BitCount=8, Depth=4):
- Reset, then idle: empty=1, full=0, sel=0, next_addr=0, flags=0. Assert reset low mid-stack (count=2): empty=1 immediately, before the next clock edge.
- CALL with pc=0x10, target=0x40: that cycle sel=1, next_addr=0x40. Then RET: sel=1, next_addr=0x11, empty=1 after the edge.
- CALLs from pc=0x10,0x20,0x30,0x40: full=1, no overflow. Fifth CALL from pc=0x50: overflow=1, full=1. Four RETs yield 0x51,0x41,0x31,0x21.
- RET while empty: sel=0, underflow=1 after the edge. clr_err pulse clears it. Simultaneous underflow event and clr_err leaves underflow=1.
- CALL from pc=0x10, then TAILCALL with pc=0x60, target=0x80: sel=1, next_addr=0x80, count stays 1. Next RET yields 0x61.
- CALL with pc=0xFF: next RET yields 0x00. With CALL_STACK_LEVEL_EN defined, level tracks 0→1→0 across the sequence.
